paddle_mov: RTL
===============

PADDLE_MOV -- requirements
Module: paddle_mov

Interface
REQ-001 The block SHALL have parameter Y_ROW, default 2: constant paddle row driven on y_barr.
REQ-002 The block SHALL have parameter X_START, default 61: paddle left-edge column after reset.
REQ-003 The block SHALL have parameter BAR_W, default 6: paddle width in cells; X_MAX = 128-BAR_W (122 at default).
REQ-004 The block SHALL have parameter DEB_CYCLES, default 50000: clk cycles a synchronised button level must be stable before it is accepted.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port btn_l, input, 1 bit: raw asynchronous left button, active-high.
REQ-008 The block SHALL have port btn_r, input, 1 bit: raw asynchronous right button, active-high.
REQ-009 The block SHALL have port move_tick, input, 1 bit: one-cycle movement strobe, same rate as the ball update.
REQ-010 The block SHALL have port freeze, input, 1 bit: when high, position holds and the FSM is forced to IDLE.
REQ-011 The block SHALL have port x_barr, output, 7 bits: paddle left-edge column, fed to the ball stage's bar-x input.
REQ-012 The block SHALL have port y_barr, output, 7 bits: paddle row, fed to the ball stage's bar-y input.
REQ-013 The block SHALL have port moving, output, 1 bit: high while the FSM is in MOV_L or MOV_R.

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser, then a per-button debounce counter that clears on any change of the synchronised level and updates the debounced level when it reaches DEB_CYCLES-1.
REQ-015 Latency from a stable raw level change to the debounced level SHALL be 2+DEB_CYCLES clk cycles (±1).
REQ-016 The FSM SHALL have states IDLE, MOV_L and MOV_R, next state from debounced levels: L only -> MOV_L; R only -> MOV_R; none or both -> IDLE; freeze=1 -> IDLE.
REQ-017 Direct MOV_L<->MOV_R transitions SHALL be legal when the debounced levels swap in one cycle.
REQ-018 x_barr SHALL change only in the cycle after a move_tick sampled in MOV_L or MOV_R with freeze=0.
REQ-019 On a qualifying move_tick, MOV_L SHALL set x_barr = max(x_barr-step, 0) and MOV_R SHALL set x_barr = min(x_barr+step, X_MAX).
REQ-020 Clamping arithmetic SHALL be done in 8 bits so that no wrap past 0 or 127 occurs.
REQ-021 step SHALL be 1 unless acceleration is enabled (REQ-029).
REQ-022 A move_tick in IDLE SHALL leave x_barr unchanged.
REQ-023 y_barr SHALL equal Y_ROW constantly.
REQ-024 A move_tick coinciding with a state change SHALL be applied using the state registered in that cycle, i.e. the old state.

Reset
REQ-025 While reset is high, the block SHALL force x_barr=X_START, state=IDLE, moving=0, all synchroniser, debounce and hold counters to 0, and debounced levels to 0.
REQ-026 The block SHALL apply reset asynchronously, abandoning any in-progress debounce or hold count immediately.
REQ-027 y_barr SHALL read Y_ROW during and after reset.

Configuration
REQ-028 The block SHALL have macro PADDLE_ACCEL_EN.
REQ-029 When PADDLE_ACCEL_EN is defined, a 4-bit saturating hold counter SHALL count qualifying move_ticks in the current direction; step SHALL be 1 while the count is <8 and 2 from the 9th tick on; the counter SHALL clear on entering IDLE or changing direction.
REQ-030 When PADDLE_ACCEL_EN is undefined, the hold counter SHALL not exist and step SHALL always be 1.

Verification (DEB_CYCLES=4)
REQ-031 Reset released with no buttons -> x_barr=61, y_barr=2, moving=0; 10 move_ticks leave x_barr=61.
REQ-032 btn_r held, then 5 move_ticks after debounce -> x_barr 61->66, moving=1; a 2-cycle btn_r glitch beforehand produces no movement.
REQ-033 x_barr=1 with btn_l held and 3 move_ticks -> x_barr 0,0,0; x_barr=121 with btn_r held -> 122 then holds 122.
REQ-034 Both buttons held -> state IDLE, x_barr constant; freeze=1 with btn_l held -> x_barr constant, moving=0.
REQ-035 PADDLE_ACCEL_EN defined, btn_r held for 10 move_ticks from 61 -> 69 after 8 ticks, 71 after 9, 73 after 10; release, then L -> step returns to 1.
REQ-036 reset asserted mid-debounce and mid-move -> outputs return to 61/IDLE in the same cycle without a clock edge.

Source files
------------

// File: rtl/paddle_mov.sv
// paddle_mov: player paddle position controller.
// Two raw buttons are synchronised and debounced, a three-state FSM picks the
// movement direction, and the paddle left edge steps once per move_tick while
// a direction is held. The row output is a constant.
// Optional feature macro: PADDLE_ACCEL_EN (hold-to-accelerate, step 2 after
// eight consecutive ticks in one direction).
module paddle_mov #(
   parameter int Y_ROW      = 2,
   parameter int X_START    = 61,
   parameter int BAR_W      = 6,
   parameter int DEB_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       move_tick,
   input  logic       freeze,
   output logic [6:0] x_barr,
   output logic [6:0] y_barr,
   output logic       moving
);

   localparam int X_MAX = 128 - BAR_W;
   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOV_L = 2'd1,
      MOV_R = 2'd2
   } state_t;

   // Index 0 is the left button, index 1 the right button.
   logic [1:0]       btn_raw;
   logic [1:0]       sync_a;
   logic [1:0]       sync_b;
   logic [1:0]       sync_last;
   logic [1:0]       deb;
   logic [CNT_W-1:0] deb_cnt [2];

   state_t     state_q;
   state_t     state_d;
   logic       tick_ok;
   logic [7:0] x_wide;
   logic [7:0] step_w;
   logic [7:0] x_next;

   assign btn_raw = {btn_r, btn_l};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         // Two-flop synchroniser bringing the raw button into the clk domain.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_a[gi] <= 1'b0;
               sync_b[gi] <= 1'b0;
            end else begin
               sync_a[gi] <= btn_raw[gi];
               sync_b[gi] <= sync_a[gi];
            end
         end

         // Debounce: any change of the synchronised level restarts the count;
         // once the level has been stable long enough it becomes the accepted level.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_last[gi] <= 1'b0;
               deb_cnt[gi]   <= '0;
               deb[gi]       <= 1'b0;
            end else begin
               sync_last[gi] <= sync_b[gi];
               if (sync_b[gi] != sync_last[gi]) begin
                  deb_cnt[gi] <= '0;
               end else if (deb_cnt[gi] == CNT_TOP) begin
                  deb[gi] <= sync_b[gi];
               end else begin
                  deb_cnt[gi] <= deb_cnt[gi] + 1'b1;
               end
            end
         end
      end
   endgenerate

   // Direction FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next direction from the debounced levels; freeze or an ambiguous pair means stand still.
   always_comb begin
      state_d = IDLE;
      if (!freeze) begin
         if (deb[0] && !deb[1]) begin
            state_d = MOV_L;
         end else if (deb[1] && !deb[0]) begin
            state_d = MOV_R;
         end
      end
   end

   assign moving  = (state_q == MOV_L) || (state_q == MOV_R);
   assign tick_ok = move_tick && !freeze && moving;

`ifdef PADDLE_ACCEL_EN
   logic [3:0] hold_cnt;

   assign step_w = (hold_cnt >= 4'd8) ? 8'd2 : 8'd1;

   // Hold counter: counts ticks in the current direction, saturates at 15,
   // and restarts whenever the paddle stops or reverses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= 4'd0;
      end else if ((state_q == IDLE) || (state_d != state_q)) begin
         hold_cnt <= 4'd0;
      end else if (tick_ok && (hold_cnt != 4'd15)) begin
         hold_cnt <= hold_cnt + 4'd1;
      end
   end
`else
   assign step_w = 8'd1;
`endif

   // Candidate position for the current direction, clamped in 8 bits so it never wraps.
   always_comb begin
      x_wide = {1'b0, x_barr};
      x_next = x_wide;
      case (state_q)
         MOV_L: begin
            x_next = (x_wide < step_w) ? 8'd0 : (x_wide - step_w);
         end
         MOV_R: begin
            x_next = ((x_wide + step_w) > 8'(X_MAX)) ? 8'(X_MAX) : (x_wide + step_w);
         end
         default: begin
            x_next = x_wide;
         end
      endcase
   end

   // Paddle position register: moves only on a qualifying tick, using the
   // state registered in that cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_barr <= 7'(X_START);
      end else if (tick_ok) begin
         x_barr <= x_next[6:0];
      end
   end

   assign y_barr = 7'(Y_ROW);

endmodule
